vic_addr_gen: RTL

Address-side counterpart of the data-bus capture logic. It drives the 14-bit VIC address for every c-, g-, p-, s-, refresh and idle access, one dot4x edge ahead of data capture. It owns the video counters (VC, VCBASE, RC), the display/idle state, and the DRAM refresh counter. It sits between the cycle sequencer (cycle_type, cycle_num, raster_line) and the external address bus mux.

---
 rtl/vic_addr_gen_pkg.sv | 37 +++
 rtl/vic_addr_gen_video_counters.sv | 84 ++++++++
 rtl/vic_addr_gen.sv | 134 +++++++++++++
 3 files changed

// File: rtl/vic_addr_gen_pkg.sv
// ============================================================================
// Module      : vic_addr_gen_pkg
// Description : Shared constants for the VIC address generator: cycle-type
//               access codes, sprite count and idle-access addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vic_addr_gen_pkg;

   // Access codes presented on cycle_type, one per half-cycle
   localparam logic [3:0] VIC_LP  = 4'd0;
   localparam logic [3:0] VIC_HS1 = 4'd1;
   localparam logic [3:0] VIC_LS2 = 4'd2;
   localparam logic [3:0] VIC_HS3 = 4'd3;
   localparam logic [3:0] VIC_LR  = 4'd4;
   localparam logic [3:0] VIC_HRC = 4'd5;
   localparam logic [3:0] VIC_HGC = 4'd6;
   localparam logic [3:0] VIC_HRX = 4'd7;
   localparam logic [3:0] VIC_HGI = 4'd8;
   localparam logic [3:0] VIC_LG  = 4'd9;
   localparam logic [3:0] VIC_LI  = 4'd10;
   localparam logic [3:0] VIC_HI  = 4'd11;

   localparam int NUM_SPRITES = 8;

   localparam logic [13:0] IDLE_ADDR     = 14'h3FFF;
   localparam logic [13:0] IDLE_ADDR_ECM = 14'h39FF;

   // Idle-fetch address; ECM pulls address bits 10:9 low like a g-access
   function automatic logic [13:0] idle_addr(input logic ecm);
      return ecm ? IDLE_ADDR_ECM : IDLE_ADDR;
   endfunction

endpackage

`default_nettype wire

// File: rtl/vic_addr_gen_video_counters.sv
// ============================================================================
// Module      : vic_video_counters
// Description : Video matrix counter VC, its line base VCBASE, row counter RC
//               and the display/idle state of the VIC graphics sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vic_video_counters
   import vic_addr_gen_pkg::*;
(
   input  logic       clk_dot4x,
   input  logic       rst_n,
   input  logic       phi_i,
   input  logic       das_i,
   input  logic       dav_i,
   input  logic [3:0] cycle_type_i,
   input  logic [6:0] cycle_num_i,
   input  logic [8:0] raster_line_i,
   input  logic       badline_i,
   output logic [9:0] vc_o,
   output logic [2:0] rc_o,
   output logic       idle_o
);

   logic [9:0] vc_q, vc_d;
   logic [9:0] vcbase_q, vcbase_d;
   logic [2:0] rc_q, rc_d;
   logic       idle_q, idle_d;
   logic       w_cycle_evt;

   // Line/cycle events fire on the low-half das strobe, i.e. once per cycle
   assign w_cycle_evt = das_i & ~phi_i;

   // Next-state for counters: das events take precedence over dav increments
   always_comb begin
      vc_d     = vc_q;
      vcbase_d = vcbase_q;
      rc_d     = rc_q;
      idle_d   = idle_q;
      if (das_i) begin
         if (w_cycle_evt && raster_line_i == 9'd0 && cycle_num_i == 7'd1)
            vcbase_d = '0;
         if (w_cycle_evt && cycle_num_i == 7'd14) begin
            vc_d = vcbase_q;
            if (badline_i)
               rc_d = '0;
         end
         if (w_cycle_evt && cycle_num_i == 7'd58 && rc_q == 3'd7) begin
            vcbase_d = vc_q;
            idle_d   = 1'b1;
         end
         // A bad line always wins over the end-of-row idle transition
         if (badline_i)
            idle_d = 1'b0;
         if (w_cycle_evt && cycle_num_i == 7'd58 && !idle_d)
            rc_d = rc_q + 3'd1;
      end else if (dav_i && cycle_type_i == VIC_LG && !idle_q) begin
         vc_d = vc_q + 10'd1;
      end
   end

   // Counter and state registers with synchronous active-low reset
   always_ff @(posedge clk_dot4x) begin
      if (!rst_n) begin
         vc_q     <= '0;
         vcbase_q <= '0;
         rc_q     <= '0;
         idle_q   <= 1'b1;
      end else begin
         vc_q     <= vc_d;
         vcbase_q <= vcbase_d;
         rc_q     <= rc_d;
         idle_q   <= idle_d;
      end
   end

   assign vc_o   = vc_q;
   assign rc_o   = rc_q;
   assign idle_o = idle_q;

endmodule

`default_nettype wire

// File: rtl/vic_addr_gen.sv
// ============================================================================
// Module      : vic_addr_gen
// Description : VIC address generator. Launches the 14-bit address for every
//               c/g/p/s/refresh/idle access on the das strobe, one edge ahead
//               of data capture. Optional macro ADDR_GEN_REFRESH_EN adds the
//               DRAM refresh counter; without it refresh accesses read 3FFF.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vic_addr_gen
   import vic_addr_gen_pkg::*;
#(
   parameter int NUM_SPR = NUM_SPRITES
) (
   input  logic                 clk_dot4x,
   input  logic                 rst_n,
   input  logic                 phi,
   input  logic                 phi_phase_start_das,
   input  logic                 phi_phase_start_dav,
   input  logic [3:0]           cycle_type,
   input  logic [6:0]           cycle_num,
   input  logic [8:0]           raster_line,
   input  logic                 badline,
   input  logic                 ecm,
   input  logic                 bmm,
   input  logic [3:0]           vm,
   input  logic [2:0]           cb,
   input  logic [2:0]           sprite_cnt,
   input  logic [11:0]          char_next,
   input  logic [NUM_SPR*8-1:0] sprite_ptr_i,
   input  logic [NUM_SPR*6-1:0] sprite_mc_i,
   output logic [13:0]          vic_addr,
   output logic                 idle
);

   logic [9:0]  w_vc;
   logic [2:0]  w_rc;
   logic        w_idle;
   logic [13:0] w_mux_addr;
   logic [13:0] w_lr_addr;
   logic [13:0] addr_q, addr_d;
   logic [7:0]  w_spr_ptr [NUM_SPR];
   logic [5:0]  w_spr_mc  [NUM_SPR];
   logic        unused_char_hi;

   // Only the low byte of the character code feeds the char-ROM address
   assign unused_char_hi = &{1'b0, char_next[11:8]};

   vic_video_counters u_counters (
      .clk_dot4x     (clk_dot4x),
      .rst_n         (rst_n),
      .phi_i         (phi),
      .das_i         (phi_phase_start_das),
      .dav_i         (phi_phase_start_dav),
      .cycle_type_i  (cycle_type),
      .cycle_num_i   (cycle_num),
      .raster_line_i (raster_line),
      .badline_i     (badline),
      .vc_o          (w_vc),
      .rc_o          (w_rc),
      .idle_o        (w_idle)
   );

   // Sprite 0 sits in the most significant slice of each packed bus
   for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr_unpack
      assign w_spr_ptr[i] = sprite_ptr_i[(NUM_SPR-1-i)*8 +: 8];
      assign w_spr_mc[i]  = sprite_mc_i[(NUM_SPR-1-i)*6 +: 6];
   end

`ifdef ADDR_GEN_REFRESH_EN
   logic [7:0] refcnt_q, refcnt_d;

   // Refresh counter: post-decrement per refresh access, reloaded at frame start
   always_comb begin
      refcnt_d = refcnt_q;
      if (phi_phase_start_das && cycle_type == VIC_LR)
         refcnt_d = refcnt_q - 8'd1;
      if (phi_phase_start_das && !phi && raster_line == 9'd0 && cycle_num == 7'd1)
         refcnt_d = 8'hFF;
   end

   // Refresh counter register
   always_ff @(posedge clk_dot4x) begin
      if (!rst_n)
         refcnt_q <= 8'hFF;
      else
         refcnt_q <= refcnt_d;
   end

   assign w_lr_addr = {6'h3F, refcnt_q};
`else
   assign w_lr_addr = IDLE_ADDR;
`endif

   // Address selection by access type for the half-cycle being launched
   always_comb begin
      w_mux_addr = idle_addr(ecm);
      case (cycle_type)
         VIC_HRC, VIC_HGC, VIC_HRX, VIC_HGI: w_mux_addr = {vm, w_vc};
         VIC_LG: begin
            if (!w_idle) begin
               if (bmm)
                  w_mux_addr = {cb[2], w_vc, w_rc};
               else
                  w_mux_addr = {cb, char_next[7:0], w_rc};
               if (ecm)
                  w_mux_addr[10:9] = 2'b00;
            end
         end
         VIC_LP:                    w_mux_addr = {vm, 7'h7F, sprite_cnt};
         VIC_HS1, VIC_LS2, VIC_HS3: w_mux_addr = {w_spr_ptr[sprite_cnt], w_spr_mc[sprite_cnt]};
         VIC_LR:                    w_mux_addr = w_lr_addr;
         default:                   w_mux_addr = idle_addr(ecm);
      endcase
   end

   // Address only moves on the das strobe and holds through the matching dav
   assign addr_d = phi_phase_start_das ? w_mux_addr : addr_q;

   // Registered address output
   always_ff @(posedge clk_dot4x) begin
      if (!rst_n)
         addr_q <= IDLE_ADDR;
      else
         addr_q <= addr_d;
   end

   assign vic_addr = addr_q;
   assign idle     = w_idle;

endmodule

`default_nettype wire
